rgb_pwm_driver: RTL and testbench
=================================

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 SHALL have parameter PERIOD, default 255: PWM frame length in clk cycles; duty range 0..PERIOD.
REQ-002 SHALL have parameter FADE_STEP, default 0: per-frame duty slew per channel; 0 = jump straight to target.
REQ-003 SHALL have port clk  input  1  system clock (12 MHz); single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  new colour target offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a target.
REQ-007 SHALL have ports in_r, in_g, in_b  input  8 each  target duty per channel, in frame cycles; values above PERIOD saturate to PERIOD.
REQ-008 SHALL have ports RGB_R, RGB_G, RGB_B  output  1 each  LED drive, active-low (0 = lit).
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse on the first cycle of each PWM frame.

Function
REQ-010 SHALL keep frame counter cnt, width $clog2(PERIOD), counting 0..PERIOD-1 and wrapping to 0 with no skipped or repeated value.
REQ-011 SHALL assert frame_start, registered, in the cycle in which cnt==0.
REQ-012 SHALL hold an active duty register per channel (duty_r, duty_g, duty_b) and a target register per channel.
REQ-013 SHALL drive RGB_x, registered, to 0 when cnt < duty_x and to 1 otherwise: one cycle of latency from cnt to pin.
REQ-014 SHALL make duty 0 fully dark (all 1s) and duty PERIOD fully lit (all 0s) across the whole frame, with no glitch cycle at the wrap.
REQ-015 SHALL drive in_ready = ~pending & ~rst, where pending is an internal flag.
REQ-016 SHALL accept a target on a cycle with in_valid & in_ready: latch saturated in_r/g/b into the targets and set pending=1 on the next edge.
REQ-017 SHALL ignore in_valid while in_ready=0; the offered data is not captured and the targets do not change.
REQ-018 SHALL update duties only at the frame boundary, defined as the cycle with cnt==PERIOD-1 and pending==1; duties never change mid-frame.
REQ-019 With FADE_STEP==0, at the boundary SHALL copy each duty from its target and clear pending.
REQ-020 With FADE_STEP>0, at the boundary SHALL move each duty toward its target by min(FADE_STEP, |target-duty|) and clear pending only when all three duties equal their targets after that update.
REQ-021 SHALL compute slew arithmetic at 9 bits with no wrap: a duty never overshoots its target and never leaves 0..PERIOD.
REQ-022 SHALL, when acceptance and the boundary fall in the same cycle (possible only with pending==0), apply the new target at the next boundary, not the current one.
REQ-023 SHALL, when in_valid targets equal the current duties, still set pending and clear it at the next boundary.

Reset
REQ-024 SHALL, while rst=1 at a clk edge, clear cnt, all duties, all targets and pending to 0.
REQ-025 SHALL drive RGB_R/G/B=1 (dark), frame_start=0 and in_ready=0 while in reset.
REQ-026 SHALL start a frame at cnt==0 on the first edge after rst falls; in_ready=1 on that cycle.
REQ-027 SHALL let reset mid-fade or mid-frame abandon all state with no partial-frame output afterward.

Verification
REQ-028 SHALL verify reset then idle: LEDs stay 1 for 3 frames, and frame_start pulses every 255 cycles.
REQ-029 SHALL verify FADE_STEP=0, target (128,0,255): from the next boundary, each frame has RGB_R=0 for exactly 128 cycles, RGB_G=1 for all 255 cycles and RGB_B=0 for all 255 cycles.
REQ-030 SHALL verify a target offered at cnt==100: duties unchanged for the rest of that frame, new duties from the following frame, and in_ready low from acceptance to the boundary.
REQ-031 SHALL verify a second in_valid while pending=1: data ignored; the first target is applied and in_ready returns high after the boundary.
REQ-032 SHALL verify FADE_STEP=16, target R 0->40: R duty per frame is 16, 32, 40, 40, and pending clears at the third boundary.
REQ-033 SHALL verify rst pulsed for 1 cycle mid-frame with duty 200: LEDs go to 1 on the next cycle, duties read 0, and cnt restarts at 0.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Three-channel active-low PWM LED driver. Duties change only at frame
// boundaries and can either jump to a new colour target or fade toward it.
module rgb_pwm_driver #(
    parameter int PERIOD    = 255,
    parameter int FADE_STEP = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic       frame_start
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef logic [8:0] val_t;

    localparam val_t          PMAX     = val_t'(PERIOD);
    localparam val_t          STEP     = val_t'(FADE_STEP);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          run;
    logic          pending;
    logic          wrap;
    logic          boundary;
    logic          accept;
    logic          settled;
    val_t          cnt_w;
    val_t          duty_r, duty_g, duty_b;
    val_t          tgt_r, tgt_g, tgt_b;
    val_t          nxt_r, nxt_g, nxt_b;

    function automatic val_t sat(input logic [7:0] v);
        val_t w;
        w = {1'b0, v};
        return (w > PMAX) ? PMAX : w;
    endfunction

    // Moves d toward t by at most STEP; the distance test keeps it from overshooting.
    function automatic val_t slew(input val_t d, input val_t t);
        val_t r;
        r = t;
        if (STEP != 0) begin
            if ((t > d) && ((t - d) > STEP))
                r = d + STEP;
            else if ((d > t) && ((d - t) > STEP))
                r = d - STEP;
        end
        return r;
    endfunction

    assign in_ready = ~pending & ~rst;
    assign accept   = in_valid & in_ready;
    // run is low only in the single cycle after reset, which parks cnt at 0 and starts frame one.
    assign wrap     = ~run | (cnt == CNT_LAST);
    assign boundary = run & (cnt == CNT_LAST) & pending;
    assign cnt_w    = val_t'(cnt);

    assign nxt_r   = slew(duty_r, tgt_r);
    assign nxt_g   = slew(duty_g, tgt_g);
    assign nxt_b   = slew(duty_b, tgt_b);
    assign settled = (nxt_r == tgt_r) && (nxt_g == tgt_g) && (nxt_b == tgt_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            run         <= 1'b0;
            pending     <= 1'b0;
            duty_r      <= '0;
            duty_g      <= '0;
            duty_b      <= '0;
            tgt_r       <= '0;
            tgt_g       <= '0;
            tgt_b       <= '0;
            RGB_R       <= 1'b1;
            RGB_G       <= 1'b1;
            RGB_B       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            cnt         <= wrap ? '0 : cnt + CW'(1);
            frame_start <= wrap;
            RGB_R       <= ~(cnt_w < duty_r);
            RGB_G       <= ~(cnt_w < duty_g);
            RGB_B       <= ~(cnt_w < duty_b);
            // boundary needs pending=1 and accept needs pending=0, so they never collide.
            if (boundary) begin
                duty_r  <= nxt_r;
                duty_g  <= nxt_g;
                duty_b  <= nxt_b;
                pending <= ~settled;
            end else if (accept) begin
                tgt_r   <= sat(in_r);
                tgt_g   <= sat(in_g);
                tgt_b   <= sat(in_b);
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: three instances (jump, fade 16, short period with fade 7)
// compared every cycle to a time-based reference model, plus directed frame measurements.
module tb_rgb_pwm_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_r, in_g, in_b;
    logic [2:0] rdy, lr, lg, lb, fs;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    int m_run[3], m_t[3], m_pend[3], e_fs[3];
    int m_duty[3][3], m_tgt[3][3], e_led[3][3];

    int lit_r[8], lit_g[8], lit_b[8], rdy_at[8];

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PERIOD(255), .FADE_STEP(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .RGB_R(lr[0]), .RGB_G(lg[0]), .RGB_B(lb[0]), .frame_start(fs[0]));

    rgb_pwm_driver #(.PERIOD(255), .FADE_STEP(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .RGB_R(lr[1]), .RGB_G(lg[1]), .RGB_B(lb[1]), .frame_start(fs[1]));

    rgb_pwm_driver #(.PERIOD(100), .FADE_STEP(7)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .RGB_R(lr[2]), .RGB_G(lg[2]), .RGB_B(lb[2]), .frame_start(fs[2]));

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int per(input int k);
        return (k == 2) ? 100 : 255;
    endfunction

    function automatic int fstep(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 16 : 7);
    endfunction

    // Reference: m_t counts cycles since the first frame began, so frame position is m_t mod period.
    task automatic model_step(input int k);
        int p, f, pos, d, g, inv[3];
        bit bnd, acc, done;
        p = per(k);
        f = fstep(k);
        inv[0] = in_r;
        inv[1] = in_g;
        inv[2] = in_b;
        if (rst) begin
            m_run[k]  = 0;
            m_t[k]    = 0;
            m_pend[k] = 0;
            e_fs[k]   = 0;
            for (int c = 0; c < 3; c++) begin
                m_duty[k][c] = 0;
                m_tgt[k][c]  = 0;
                e_led[k][c]  = 1;
            end
            return;
        end
        pos = m_t[k] % p;
        bnd = (m_run[k] != 0) && (pos == p - 1) && (m_pend[k] != 0);
        acc = in_valid && (m_pend[k] == 0);
        for (int c = 0; c < 3; c++)
            e_led[k][c] = ((m_run[k] != 0) && (pos < m_duty[k][c])) ? 0 : 1;
        if (m_run[k] != 0) m_t[k]++;
        else begin
            m_run[k] = 1;
            m_t[k]   = 0;
        end
        e_fs[k] = ((m_t[k] % p) == 0) ? 1 : 0;
        if (bnd) begin
            done = 1'b1;
            for (int c = 0; c < 3; c++) begin
                d = m_duty[k][c];
                g = m_tgt[k][c];
                if (f == 0) d = g;
                else if (g > d) d = (d + f > g) ? g : d + f;
                else d = (d - f < g) ? g : d - f;
                m_duty[k][c] = d;
                if (d != g) done = 1'b0;
            end
            m_pend[k] = done ? 0 : 1;
        end
        if (acc) begin
            for (int c = 0; c < 3; c++)
                m_tgt[k][c] = (inv[c] > p) ? p : inv[c];
            m_pend[k] = 1;
        end
    endtask

    always @(posedge clk)
        for (int k = 0; k < 3; k++) model_step(k);

    always @(negedge clk)
        if (chk_en)
            for (int k = 0; k < 3; k++) begin
                check($sformatf("d%0d_led_r", k), lr[k], e_led[k][0]);
                check($sformatf("d%0d_led_g", k), lg[k], e_led[k][1]);
                check($sformatf("d%0d_led_b", k), lb[k], e_led[k][2]);
                check($sformatf("d%0d_frame_start", k), fs[k], e_fs[k]);
                check($sformatf("d%0d_in_ready", k), rdy[k], (m_pend[k] == 0 && !rst) ? 1 : 0);
            end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input int r, input int g, input int b);
        cyc(1);
        in_valid = 1'b1;
        in_r = 8'(r);
        in_g = 8'(g);
        in_b = 8'(b);
    endtask

    // Finds the next frame_start of instance k, then counts lit cycles for n back-to-back frames.
    task automatic measure(input int k, input int n);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!fs[k] && w < 600);
        check("fs_found", fs[k], 1);
        for (int f = 0; f < n; f++) begin
            rdy_at[f] = rdy[k];
            lit_r[f] = 0;
            lit_g[f] = 0;
            lit_b[f] = 0;
            for (int i = 0; i < 255; i++) begin
                @(negedge clk);
                if (!lr[k]) lit_r[f]++;
                if (!lg[k]) lit_g[f]++;
                if (!lb[k]) lit_b[f]++;
            end
            check("fs_period", fs[k], 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_r = 8'd0;
        in_g = 8'd0;
        in_b = 8'd0;
        cyc(2);
        chk_en = 1'b1;
        cyc(1);
        @(negedge clk);
        check("rst_ready", rdy[0], 0);
        check("rst_led_r", lr[0], 1);
        check("rst_fs", fs[0], 0);

        // idle frames stay dark
        cyc(1);
        rst = 1'b0;
        measure(0, 3);
        for (int f = 0; f < 3; f++) begin
            check("idle_r", lit_r[f], 0);
            check("idle_g", lit_g[f], 0);
            check("idle_b", lit_b[f], 0);
        end

        // jump to (128,0,255)
        offer(128, 0, 255);
        cyc(1);
        in_valid = 1'b0;
        measure(0, 2);
        for (int f = 0; f < 2; f++) begin
            check("jump_r", lit_r[f], 128);
            check("jump_g", lit_g[f], 0);
            check("jump_b", lit_b[f], 255);
        end

        // target offered at cnt==100 waits for the boundary
        repeat (100) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_r = 8'd10;
        in_g = 8'd20;
        in_b = 8'd30;
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_ready_low", rdy[0], 0);
        measure(0, 1);
        check("mid_ready_back", rdy_at[0], 1);
        check("mid_r", lit_r[0], 10);
        check("mid_g", lit_g[0], 20);
        check("mid_b", lit_b[0], 30);

        // second offer while pending is dropped
        offer(50, 60, 70);
        offer(200, 200, 200);
        cyc(1);
        in_valid = 1'b0;
        @(negedge clk);
        check("busy_ready_low", rdy[0], 0);
        measure(0, 2);
        check("busy_ready_back", rdy_at[0], 1);
        for (int f = 0; f < 2; f++) begin
            check("busy_r", lit_r[f], 50);
            check("busy_g", lit_g[f], 60);
            check("busy_b", lit_b[f], 70);
        end

        // fade 0 -> 40 in steps of 16
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(3);
        in_valid = 1'b1;
        in_r = 8'd40;
        in_g = 8'd0;
        in_b = 8'd0;
        cyc(1);
        in_valid = 1'b0;
        measure(1, 4);
        check("fade_r0", lit_r[0], 16);
        check("fade_r1", lit_r[1], 32);
        check("fade_r2", lit_r[2], 40);
        check("fade_r3", lit_r[3], 40);
        check("fade_g", lit_g[3], 0);
        check("fade_rdy0", rdy_at[0], 0);
        check("fade_rdy1", rdy_at[1], 0);
        check("fade_rdy2", rdy_at[2], 1);
        check("fade_rdy3", rdy_at[3], 1);

        // acceptance on the last cycle of a frame lands one boundary later
        repeat (254) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_r = 8'd100;
        in_g = 8'd100;
        in_b = 8'd100;
        cyc(1);
        in_valid = 1'b0;
        measure(0, 2);
        check("edge_r0", lit_r[0], 40);
        check("edge_r1", lit_r[1], 100);
        check("edge_rdy0", rdy_at[0], 0);
        check("edge_rdy1", rdy_at[1], 1);

        // one-cycle reset mid-frame at duty 200
        offer(200, 200, 200);
        cyc(1);
        in_valid = 1'b0;
        measure(0, 1);
        check("pre_rst_r", lit_r[0], 200);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_lit", lr[0], 0);
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_led", lr[0], 1);
        check("post_rst_duty", u_dut0.duty_r, 0);
        check("post_rst_cnt", u_dut0.cnt, 0);
        check("post_rst_ready", rdy[0], 1);
        measure(0, 1);
        check("post_rst_frame", lit_r[0], 0);

        // random traffic, including occasional reset
        for (int i = 0; i < 12000; i++) begin
            cyc(1);
            rst      = ($urandom_range(0, 2999) == 0);
            in_valid = ($urandom_range(0, 5) == 0);
            in_r     = 8'($urandom_range(0, 255));
            in_g     = 8'($urandom_range(0, 255));
            in_b     = 8'($urandom_range(0, 255));
        end
        rst = 1'b0;
        in_valid = 1'b0;
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
